// File: rtl/pwm_multi_pkg.sv
// +----------------------------------------------------------------------------+
// | pwm_multi_pkg : register map and control types for the multi-channel PWM   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package pwm_multi_pkg;

    localparam int CH_STRIDE = 16;

    localparam logic [3:0] REG_DUTY   = 4'h0;
    localparam logic [3:0] REG_PERIOD = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;
    localparam logic [3:0] REG_CNT    = 4'hC;

    typedef struct packed {
        logic mode;
        logic pol;
        logic en;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pwm_multi_channel.sv
// +----------------------------------------------------------------------------+
// | pwm_multi_channel : one PWM channel with shadowed duty/period and counter. |
// | Optional up/down counting when PWM_CENTER_ALIGN_EN is defined.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_multi_channel
    import pwm_multi_pkg::*;
#(
    parameter int CtrWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                duty_we_i,
    input  logic                period_we_i,
    input  logic                ctrl_we_i,
    input  logic [CtrWidth-1:0] wdata_i,
    input  ctrl_t               ctrl_wdata_i,
    output logic [CtrWidth-1:0] duty_o,
    output logic [CtrWidth-1:0] period_o,
    output logic [CtrWidth-1:0] cnt_o,
    output ctrl_t               ctrl_o,
    output logic                pwm_o
);

    logic [CtrWidth-1:0] duty_pend_q, duty_pend_d, period_pend_q, period_pend_d;
    logic [CtrWidth-1:0] duty_act_q, duty_act_d, period_act_q, period_act_d;
    logic [CtrWidth-1:0] cnt_q, cnt_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic                pwm_q, pwm_d;
    logic                load;
`ifdef PWM_CENTER_ALIGN_EN
    logic                dir_q, dir_d;     // 0 = counting up, 1 = counting down
    logic                first_q, first_d;
`endif

    always_comb begin
        duty_pend_d   = duty_we_i   ? wdata_i : duty_pend_q;
        period_pend_d = period_we_i ? wdata_i : period_pend_q;
        ctrl_d        = ctrl_we_i ? ctrl_wdata_i : ctrl_q;
`ifndef PWM_CENTER_ALIGN_EN
        ctrl_d.mode   = 1'b0;
`endif
        duty_act_d    = duty_act_q;
        period_act_d  = period_act_q;
        cnt_d         = cnt_q;
        load          = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d         = dir_q;
        first_d       = 1'b0;
`endif
        if (!ctrl_q.en) begin
            cnt_d = '0;
            load  = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
            dir_d   = 1'b0;
            first_d = 1'b1;
        end else if (ctrl_q.mode) begin
            // Turnaround cycles dwell on the end value, giving 2*period cycles per period
            load = first_q || (dir_q && (cnt_q == '0));
            if (!dir_q) begin
                if ((period_act_q == '0) || (cnt_q >= period_act_q - 1'b1)) begin
                    dir_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    dir_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
        end else begin
            load  = (cnt_q >= period_act_q);
            cnt_d = load ? '0 : cnt_q + 1'b1;
        end
        if (load) begin
            duty_act_d   = duty_pend_q;
            period_act_d = period_pend_q;
        end
        pwm_d = ctrl_q.en ? ((cnt_q < duty_act_q) ^ ctrl_q.pol) : ctrl_q.pol;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_pend_q   <= '0;
            period_pend_q <= '0;
            duty_act_q    <= '0;
            period_act_q  <= '0;
            cnt_q         <= '0;
            ctrl_q        <= '0;
            pwm_q         <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q         <= 1'b0;
            first_q       <= 1'b0;
`endif
        end else begin
            duty_pend_q   <= duty_pend_d;
            period_pend_q <= period_pend_d;
            duty_act_q    <= duty_act_d;
            period_act_q  <= period_act_d;
            cnt_q         <= cnt_d;
            ctrl_q        <= ctrl_d;
            pwm_q         <= pwm_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q         <= dir_d;
            first_q       <= first_d;
`endif
        end
    end

    assign duty_o   = duty_pend_q;
    assign period_o = period_pend_q;
    assign cnt_o    = cnt_q;
    assign ctrl_o   = ctrl_q;
    assign pwm_o    = pwm_q;

endmodule

`default_nettype wire

// File: rtl/pwm_multi_ctrl.sv
// +----------------------------------------------------------------------------+
// | pwm_multi_ctrl : bus-mapped multi-channel PWM (decode, byte merge, readback)|
// | Define PWM_CENTER_ALIGN_EN to enable CTRL.MODE up/down counting.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_multi_ctrl
    import pwm_multi_pkg::*;
#(
    parameter int NumChannels = 12,
    parameter int CtrWidth    = 16,
    parameter int BusWidth    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   device_req_i,
    input  logic [BusWidth-1:0]    device_addr_i,
    input  logic                   device_we_i,
    input  logic [3:0]             device_be_i,
    input  logic [BusWidth-1:0]    device_wdata_i,
    output logic                   device_rvalid_o,
    output logic [BusWidth-1:0]    device_rdata_o,
    output logic [NumChannels-1:0] pwm_o
);

    localparam int ChLsb = $clog2(CH_STRIDE);

    logic [ChLsb-1:0]       reg_off;
    logic [9-ChLsb:0]       ch_idx;
    logic [NumChannels-1:0] sel;
    logic [BusWidth-1:0]    ch_word [NumChannels];
    logic [BusWidth-1:0]    reg_word, wr_word;
    logic                   wr;
    logic                   rvalid_q, rvalid_d;
    logic [BusWidth-1:0]    rdata_q, rdata_d;
    logic                   unused_bits;

    assign reg_off     = device_addr_i[ChLsb-1:0];
    assign ch_idx      = device_addr_i[9:ChLsb];
    assign wr          = device_req_i & device_we_i;
    assign unused_bits = ^{device_addr_i[BusWidth-1:10], wr_word};

    for (genvar i = 0; i < NumChannels; i++) begin : g_ch
        logic [CtrWidth-1:0] duty, period, cnt;
        ctrl_t               ctrl;
        logic [BusWidth-1:0] word;

        assign sel[i] = (ch_idx == (10 - ChLsb)'(i));

        // Misaligned offsets match no case item and read back as zero
        always_comb begin
            word = '0;
            case (reg_off)
                REG_DUTY:   word[CtrWidth-1:0] = duty;
                REG_PERIOD: word[CtrWidth-1:0] = period;
                REG_CTRL:   word[2:0]          = ctrl;
                REG_CNT:    word[CtrWidth-1:0] = cnt;
                default:    word               = '0;
            endcase
        end
        assign ch_word[i] = word;

        pwm_multi_channel #(
            .CtrWidth (CtrWidth)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .duty_we_i    (wr && sel[i] && (reg_off == REG_DUTY)),
            .period_we_i  (wr && sel[i] && (reg_off == REG_PERIOD)),
            .ctrl_we_i    (wr && sel[i] && (reg_off == REG_CTRL)),
            .wdata_i      (wr_word[CtrWidth-1:0]),
            .ctrl_wdata_i (ctrl_t'(wr_word[2:0])),
            .duty_o       (duty),
            .period_o     (period),
            .cnt_o        (cnt),
            .ctrl_o       (ctrl),
            .pwm_o        (pwm_o[i])
        );
    end

    always_comb begin
        reg_word = '0;
        for (int i = 0; i < NumChannels; i++) begin
            if (sel[i]) begin
                reg_word = ch_word[i];
            end
        end
        for (int b = 0; b < 4; b++) begin
            wr_word[8*b +: 8] = device_be_i[b] ? device_wdata_i[8*b +: 8] : reg_word[8*b +: 8];
        end
        rvalid_d = device_req_i;
        rdata_d  = (device_req_i && !device_we_i) ? reg_word : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_pwm_multi_ctrl : scoreboard bench for pwm_multi_ctrl                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_multi_ctrl;
    import pwm_multi_pkg::*;

    localparam int NCH = 12;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req = 1'b0;
    logic [31:0]     addr = '0;
    logic            we = 1'b0;
    logic [3:0]      be = '0;
    logic [31:0]     wdata = '0;
    logic            rvalid;
    logic [31:0]     rdata;
    logic [NCH-1:0]  pwm;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    pwm_multi_ctrl #(.NumChannels(NCH), .CtrWidth(16), .BusWidth(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .device_req_i    (req),
        .device_addr_i   (addr),
        .device_we_i     (we),
        .device_be_i     (be),
        .device_wdata_i  (wdata),
        .device_rvalid_o (rvalid),
        .device_rdata_o  (rdata),
        .pwm_o           (pwm)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] ra(input int ch, input logic [3:0] off);
        return 32'(ch * CH_STRIDE) + {28'd0, off};
    endfunction

    // Called at posedge+1; returns at the next posedge+1 so calls chain back-to-back
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] exp, input string n);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        exp_q.push_back(exp);
        name_q.push_back(n);
        @(posedge clk_i); #1;
        req = 1'b0; we = 1'b0; be = '0; wdata = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, a, 4'hF, d, 32'h0, "wr_rdata");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string n);
        bus(1'b0, a, 4'h0, 32'h0, exp, n);
    endtask

    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(negedge clk_i);
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 with nothing outstanding, expected 0");
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check(n, rdata, e);
                end
            end
        end
    end

    initial begin
        int highs;
        logic [7:0] pat;

        // Reset state
        #2;
        check("rst_pwm", 32'(pwm), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Basic edge-aligned: DUTY=3, PERIOD=7
        wr(ra(0, REG_DUTY), 32'd3);
        wr(ra(0, REG_PERIOD), 32'd7);
        rd(ra(0, REG_DUTY), 32'd3, "duty_rb");
        rd(ra(0, REG_PERIOD), 32'd7, "period_rb");
        wr(ra(0, REG_CTRL), 32'h1);
        fork
            begin
                for (int k = 0; k < 9; k++) rd(ra(0, REG_CNT), 32'(k % 8), "cnt_seq");
            end
            begin
                for (int j = 0; j < 16; j++) begin
                    @(posedge clk_i); #1;
                    check("pwm_3of8", 32'(pwm[0]), 32'((j % 8) < 3));
                end
            end
        join

        // Shadowing: DUTY=6 written while cnt=2 applies from the next period
        wr(ra(0, REG_CTRL), 32'h0);
        wr(ra(0, REG_CTRL), 32'h1);
        fork
            begin
                @(posedge clk_i); #1;
                @(posedge clk_i); #1;
                wr(ra(0, REG_DUTY), 32'd6);
                rd(ra(0, REG_DUTY), 32'd6, "duty_pending_rb");
            end
            begin
                for (int j = 0; j < 24; j++) begin
                    @(posedge clk_i); #1;
                    check("pwm_shadow", 32'(pwm[0]), (j < 8) ? 32'((j % 8) < 3) : 32'((j % 8) < 6));
                end
            end
        join

        // Duty bounds
        wr(ra(0, REG_CTRL), 32'h0);
        wr(ra(0, REG_DUTY), 32'd0);
        wr(ra(0, REG_CTRL), 32'h1);
        highs = 0;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk_i); #1;
            highs += int'(pwm[0]);
        end
        check("duty0_highs", 32'(highs), 32'd0);

        wr(ra(0, REG_CTRL), 32'h0);
        wr(ra(0, REG_DUTY), 32'd9);
        wr(ra(0, REG_CTRL), 32'h1);
        highs = 0;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk_i); #1;
            highs += int'(pwm[0]);
        end
        check("duty_gt_period_highs", 32'(highs), 32'd16);

        // Idle polarity
        wr(ra(0, REG_CTRL), 32'h2);
        @(posedge clk_i); #1;
        check("pol_idle", 32'(pwm[0]), 32'h1);
        check("other_ch_idle", 32'(pwm[1]), 32'h0);
        rd(ra(0, REG_CTRL), 32'h2, "ctrl_rb");

        // Byte enables and dropped upper bits
        bus(1'b1, ra(0, REG_DUTY), 4'b0001, 32'h0000_ABCD, 32'h0, "wr_rdata");
        rd(ra(0, REG_DUTY), 32'h0000_00CD, "duty_be0");
        wr(ra(0, REG_DUTY), 32'h1234_5678);
        rd(ra(0, REG_DUTY), 32'h0000_5678, "duty_trunc");
        wr(ra(2, REG_CTRL), 32'hFFFF_FFFC);
`ifdef PWM_CENTER_ALIGN_EN
        rd(ra(2, REG_CTRL), 32'h4, "ctrl_trunc");
`else
        rd(ra(2, REG_CTRL), 32'h0, "ctrl_trunc");
`endif
        wr(ra(0, REG_CNT), 32'h5);
        rd(ra(0, REG_CNT), 32'h0, "cnt_ro");

        // Unmapped and misaligned accesses, back-to-back reads
        rd(ra(NCH, REG_DUTY), 32'h0, "unmapped_ch");
        rd(32'h2, 32'h0, "misaligned");
        wr(32'h2, 32'hFFFF_FFFF);
        wr(ra(1, REG_DUTY), 32'h55);
        rd(ra(0, REG_DUTY), 32'h5678, "b2b_ch0");
        rd(ra(1, REG_DUTY), 32'h55, "b2b_ch1");
        rd(ra(1, REG_PERIOD), 32'h0, "b2b_ch1_period");

`ifdef PWM_CENTER_ALIGN_EN
        // Center-aligned: cnt 0,1,2,3,3,2,1,0 -> high on 0,1 up and 1,0 down
        wr(ra(0, REG_CTRL), 32'h0);
        wr(ra(0, REG_DUTY), 32'd2);
        wr(ra(0, REG_PERIOD), 32'd4);
        wr(ra(0, REG_CTRL), 32'h5);
        pat = 8'b1100_0011;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk_i); #1;
            check("center_pwm", 32'(pwm[0]), 32'(pat[j % 8]));
        end
`else
        pat = 8'h0;
`endif

        // Asynchronous reset mid-run
        wr(ra(0, REG_CTRL), 32'h2);
        @(posedge clk_i); #1;
        check("pre_reset_pwm", 32'(pwm[0]), 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm), 32'h0 | 32'(pat & 8'h0));
        check("async_rst_rvalid", 32'(rvalid), 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        rd(ra(0, REG_DUTY), 32'h0, "post_rst_duty");
        rd(ra(0, REG_PERIOD), 32'h0, "post_rst_period");
        rd(ra(0, REG_CTRL), 32'h0, "post_rst_ctrl");
        rd(ra(0, REG_CNT), 32'h0, "post_rst_cnt");
        rd(ra(1, REG_DUTY), 32'h0, "post_rst_ch1");

        repeat (3) @(posedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
